// File: rtl/cpld_pkg.sv
// ============================================================================
// Module      : cpld_pkg
// Description : Shared types and helpers for the chained row-pipeline stage:
//               FILL/SCAN state encoding, derived-width helpers and the
//               one-column shift/rotate row transform.
// Revision    : 1.0 - parametrised successor to the fixed 5-bit row stage
// ============================================================================
`default_nettype none

package cpld_pkg;

  // Widest row the transform helper handles; rows are zero-extended into it.
  localparam int MAX_W = 64;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    SCAN = 1'b1
  } state_e;

  // Row-index width for a frame of 'depth' rows.
  function automatic int pw_of(input int depth);
    return $clog2(depth);
  endfunction

  // Select-encoding width: lowest-set-bit index plus a "none set" flag on top.
  function automatic int sw_of(input int width);
    return $clog2(width) + 1;
  endfunction

  // Move a 'width'-bit row right by one column. mode=0 feeds a zero into the
  // top column, mode=1 wraps the dropped bit 0 around into it.
  function automatic logic [MAX_W-1:0] xf_row(input logic [MAX_W-1:0] row,
                                              input int               width,
                                              input logic             mode);
    logic [MAX_W-1:0] res;
    res             = row >> 1;
    res[width-1]    = mode & row[0];
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/onehot_lsb_enc.sv
// ============================================================================
// Module      : onehot_lsb_enc
// Description : Combinational encoder returning the index of the lowest set
//               bit of 'sel' with MSB=0, or {1'b1, 0...} when no bit is set.
//               Multi-hot inputs resolve to the lowest set bit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module onehot_lsb_enc #(
  parameter int WIDTH = 5,
  parameter int SW    = $clog2(WIDTH) + 1
) (
  input  logic [WIDTH-1:0] sel,
  output logic [SW-1:0]    enc
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    enc = {1'b1, {(SW-1){1'b0}}};
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (sel[i]) begin
        enc = {1'b0, (SW-1)'(i)};
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/cpld_row_frame.sv
// ============================================================================
// Module      : cpld_row_frame
// Description : Buffers a frame of DEPTH rows from the left neighbour, then
//               replays it to the right neighbour shifted or rotated right by
//               one column, tagged with row index and last-row flag. Each
//               replayed row is also written back into the frame. A
//               registered lowest-set-bit encoder of 'sel' runs alongside.
// Revision    : 1.0 - parametrised successor to the fixed 5-bit row stage
// ============================================================================
`default_nettype none

module cpld_row_frame
  import cpld_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int DEPTH = 8,
  parameter int PW    = pw_of(DEPTH),
  parameter int SW    = sw_of(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] left_in2,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             rot,
  input  logic [WIDTH-1:0] sel,
  output logic [SW-1:0]    sel_out2,
  output logic [WIDTH-1:0] right_out2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PW-1:0]    pos_c,
  output logic             last_row
);

  localparam logic [0:0]    c_FILL     = FILL;
  localparam logic [0:0]    c_SCAN     = SCAN;
  localparam logic [PW-1:0] c_LAST     = PW'(DEPTH - 1);
  localparam logic [SW-1:0] c_SEL_NONE = {1'b1, {(SW-1){1'b0}}};

  // Reset is asserted asynchronously; its release is expected to arrive
  // already aligned to clk from the system reset controller, so the first
  // accept can happen on the first edge with rst high.

  logic [0:0]       r_state;
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic             r_mode;
  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] r_frame [DEPTH];
  logic [SW-1:0]    r_sel_enc;
  logic [SW-1:0]    w_sel_enc;

  // Row transform at this block's width.
  function automatic logic [WIDTH-1:0] xf(input logic [WIDTH-1:0] r, input logic m);
    return WIDTH'(xf_row(MAX_W'(r), WIDTH, m));
  endfunction

  onehot_lsb_enc #(
    .WIDTH (WIDTH),
    .SW    (SW)
  ) u_sel_enc (
    .sel (sel),
    .enc (w_sel_enc)
  );

  // Frame FSM: collect DEPTH rows, then replay them with read-modify-write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= c_FILL;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_mode   <= 1'b0;
      r_out    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_frame[i] <= '0;
      end
    end else begin
      case (r_state)
        c_FILL: begin
          if (in_valid) begin
            r_frame[r_wr_ptr] <= left_in2;
            if (r_wr_ptr == c_LAST) begin
              // Row 0 is already stored; the mode being latched now applies.
              r_mode   <= rot;
              r_wr_ptr <= '0;
              r_rd_ptr <= '0;
              r_out    <= xf(r_frame[0], rot);
              r_state  <= c_SCAN;
            end else begin
              r_wr_ptr <= r_wr_ptr + PW'(1);
            end
          end
        end
        c_SCAN: begin
          if (out_ready) begin
            r_frame[r_rd_ptr] <= xf(r_frame[r_rd_ptr], r_mode);
            r_rd_ptr          <= r_rd_ptr + PW'(1);
            r_out             <= xf(r_frame[r_rd_ptr + PW'(1)], r_mode);
            if (r_rd_ptr == c_LAST) begin
              r_rd_ptr <= '0;
              r_wr_ptr <= '0;
              r_state  <= c_FILL;
            end
          end
        end
        default: r_state <= c_FILL;
      endcase
    end
  end

  // Column-select encoding, registered every cycle regardless of state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sel_enc <= c_SEL_NONE;
    end else begin
      r_sel_enc <= w_sel_enc;
    end
  end

  assign in_ready   = (r_state == c_FILL);
  assign out_valid  = (r_state == c_SCAN);
  assign right_out2 = r_out;
  assign pos_c      = r_rd_ptr;
  assign last_row   = (r_state == c_SCAN) && (r_rd_ptr == c_LAST);
  assign sel_out2   = r_sel_enc;

endmodule

`default_nettype wire

// File: tb/tb_cpld_row_frame.sv
// ============================================================================
// Module      : tb_cpld_row_frame
// Description : Directed self-checking bench for cpld_row_frame (WIDTH=5,
//               DEPTH=8) with hand-computed expected rows.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_cpld_row_frame;

  localparam int WIDTH = 5;
  localparam int DEPTH = 8;
  localparam int PW    = 3;
  localparam int SW    = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] left_in2 = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             rot = 1'b0;
  logic [WIDTH-1:0] sel = '0;
  logic [SW-1:0]    sel_out2;
  logic [WIDTH-1:0] right_out2;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [PW-1:0]    pos_c;
  logic             last_row;

  int total = 0;
  int bad   = 0;

  typedef logic [WIDTH-1:0] row_arr_t [DEPTH];

  // Frame A and its shifted / rotated images.
  row_arr_t rows_a    = '{5'h1F, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h08};
  row_arr_t shf_a     = '{5'h0F, 5'h00, 5'h01, 5'h01, 5'h02, 5'h02, 5'h03, 5'h04};
  row_arr_t rot_a     = '{5'h1F, 5'h10, 5'h01, 5'h11, 5'h02, 5'h12, 5'h03, 5'h04};
  // Frame B shifted.
  row_arr_t rows_b    = '{5'h15, 5'h0A, 5'h1E, 5'h03, 5'h10, 5'h07, 5'h19, 5'h0C};
  row_arr_t shf_b     = '{5'h0A, 5'h05, 5'h0F, 5'h01, 5'h08, 5'h03, 5'h0C, 5'h06};
  // Frame C rotated.
  row_arr_t rows_c    = '{5'h11, 5'h12, 5'h13, 5'h14, 5'h15, 5'h16, 5'h17, 5'h18};
  row_arr_t rot_c     = '{5'h18, 5'h09, 5'h19, 5'h0A, 5'h1A, 5'h0B, 5'h1B, 5'h0C};

  cpld_row_frame #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .left_in2   (left_in2),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .rot        (rot),
    .sel        (sel),
    .sel_out2   (sel_out2),
    .right_out2 (right_out2),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .pos_c      (pos_c),
    .last_row   (last_row)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) tick();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (sel_out2 !== 4'b1000) begin bad++; $display("FAIL reset_sel_out2 got=%b want=1000", sel_out2); end
    total++; if (right_out2 !== 5'h00) begin bad++; $display("FAIL reset_right_out2 got=%h want=00", right_out2); end
    total++; if (pos_c !== 3'd0) begin bad++; $display("FAIL reset_pos_c got=%0d want=0", pos_c); end
    total++; if (last_row !== 1'b0) begin bad++; $display("FAIL reset_last_row got=%b want=0", last_row); end
    rst = 1'b1;
    tick();
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL idle_after_release in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
  endtask

  // Push 'n' rows of a frame at full rate with the given mode.
  task automatic fill_rows(input row_arr_t rows, input int n, input logic rot_v);
    for (int i = 0; i < n; i++) begin
      left_in2 = rows[i];
      in_valid = 1'b1;
      rot      = rot_v;
      total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        bad++; $display("FAIL fill_handshake row=%0d in_ready=%b out_valid=%b want 1/0", i, in_ready, out_valid);
      end
      tick();
    end
    in_valid = 1'b0;
    left_in2 = '0;
  endtask

  // Drain rows 0..stop_at-1, optionally stalling at one index and toggling
  // rot each cycle. A full drain also checks the return to FILL.
  task automatic scan_rows(input row_arr_t exp, input int stop_at,
                           input int stall_at, input int stall_len, input logic toggle);
    out_ready = 1'b1;
    for (int i = 0; i < stop_at; i++) begin
      if (i == stall_at) begin
        out_ready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          tick();
          total++; if (out_valid !== 1'b1 || right_out2 !== exp[i] || pos_c !== PW'(i)) begin
            bad++; $display("FAIL stall_hold row=%0d cyc=%0d valid=%b data=%h pos=%0d want 1/%h/%0d",
                            i, s, out_valid, right_out2, pos_c, exp[i], i);
          end
        end
        out_ready = 1'b1;
      end
      total++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        bad++; $display("FAIL scan_handshake row=%0d out_valid=%b in_ready=%b want 1/0", i, out_valid, in_ready);
      end
      total++; if (right_out2 !== exp[i]) begin
        bad++; $display("FAIL scan_data row=%0d got=%h want=%h", i, right_out2, exp[i]);
      end
      total++; if (pos_c !== PW'(i) || last_row !== (i == DEPTH - 1)) begin
        bad++; $display("FAIL scan_pos row=%0d pos_c=%0d last_row=%b want %0d/%b", i, pos_c, last_row, i, (i == DEPTH - 1));
      end
      if (toggle) rot = ~rot;
      tick();
    end
    out_ready = 1'b0;
    if (stop_at == DEPTH) begin
      total++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || last_row !== 1'b0) begin
        bad++; $display("FAIL back_to_fill in_ready=%b out_valid=%b last_row=%b want 1/0/0", in_ready, out_valid, last_row);
      end
    end
  endtask

  task automatic test_shift();
    fill_rows(rows_a, DEPTH, 1'b0);
    scan_rows(shf_a, DEPTH, -1, 0, 1'b0);
  endtask

  task automatic test_rotate_toggle();
    fill_rows(rows_a, DEPTH, 1'b1);
    scan_rows(rot_a, DEPTH, -1, 0, 1'b1);
  endtask

  task automatic test_stall();
    fill_rows(rows_b, DEPTH, 1'b0);
    scan_rows(shf_b, DEPTH, 2, 3, 1'b0);
  endtask

  task automatic test_back_to_back();
    // Refill immediately with a different frame; nothing of B may leak.
    fill_rows(rows_c, DEPTH, 1'b1);
    scan_rows(rot_c, DEPTH, 6, 1, 1'b0);
  endtask

  task automatic test_sel();
    logic [WIDTH-1:0] sv [4];
    logic [SW-1:0]    ev [4];
    sv = '{5'b00100, 5'b10010, 5'b00000, 5'b10000};
    ev = '{4'b0010,  4'b0001,  4'b1000,  4'b0100};
    for (int i = 0; i < 4; i++) begin
      sel = sv[i];
      tick();
      total++; if (sel_out2 !== ev[i]) begin
        bad++; $display("FAIL sel_enc sel=%b got=%b want=%b", sv[i], sel_out2, ev[i]);
      end
    end
    sel = 5'b01000;
    #1;
    total++; if (sel_out2 !== 4'b0100) begin
      bad++; $display("FAIL sel_latency got=%b want=0100 before edge", sel_out2);
    end
    tick();
    total++; if (sel_out2 !== 4'b0011) begin
      bad++; $display("FAIL sel_enc sel=01000 got=%b want=0011", sel_out2);
    end
  endtask

  task automatic test_reset_mid_scan();
    fill_rows(rows_a, DEPTH, 1'b0);
    scan_rows(shf_a, 5, -1, 0, 1'b0);
    total++; if (pos_c !== 3'd5 || out_valid !== 1'b1) begin
      bad++; $display("FAIL pre_reset_pos pos_c=%0d out_valid=%b want 5/1", pos_c, out_valid);
    end
    rst = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || pos_c !== 3'd0 ||
                 last_row !== 1'b0 || right_out2 !== 5'h00 || sel_out2 !== 4'b1000) begin
      bad++; $display("FAIL async_reset valid=%b ready=%b pos=%0d last=%b data=%h sel=%b want 0/1/0/0/00/1000",
                      out_valid, in_ready, pos_c, last_row, right_out2, sel_out2);
    end
    tick();
    rst = 1'b1;
    // Partial fill then a second reset mid-FILL.
    fill_rows(rows_b, 3, 1'b0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    fill_rows(rows_c, DEPTH, 1'b1);
    scan_rows(rot_c, DEPTH, -1, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_shift();
    test_rotate_toggle();
    test_stall();
    test_back_to_back();
    test_sel();
    test_reset_mid_scan();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
